// File: rtl/bram_delay_ctrl.sv
// Address/sequence controller for a run-time-adjustable BRAM_SDP_MACRO delay line.
// Optional load statistics ports are enabled by defining BRAM_DELAY_CTRL_STATS_EN.
module bram_delay_ctrl #(
  parameter int unsigned ADDR_BITS     = 10,
  parameter int unsigned LATENCY       = 2,
  parameter int unsigned DEFAULT_DELAY = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [ADDR_BITS:0]   delay_in,
  input  logic                 delay_load,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_en,
  output logic                 regce,
  output logic [ADDR_BITS:0]   delay_cur,
  output logic                 dout_valid,
  output logic                 err_range
`ifdef BRAM_DELAY_CTRL_STATS_EN
  ,
  output logic [15:0]          reload_cnt,
  output logic [15:0]          rejected_cnt
`endif
);

  localparam logic [ADDR_BITS:0]   DELAY_MIN = (ADDR_BITS+1)'(LATENCY + 1);
  localparam logic [ADDR_BITS:0]   DELAY_MAX = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   DELAY_RST = (ADDR_BITS+1)'(DEFAULT_DELAY);
  localparam logic [ADDR_BITS-1:0] LAT_A     = ADDR_BITS'(LATENCY);

  typedef enum logic {FILL, RUN} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] ctr;
  logic [ADDR_BITS:0]   fill_cnt;
  logic                 in_range;
  logic                 load_ok;
  logic                 load_bad;
  logic                 fill_last;

  always_comb begin
    in_range  = (delay_in >= DELAY_MIN) && (delay_in <= DELAY_MAX);
    load_ok   = delay_load && in_range;
    load_bad  = delay_load && !in_range;
    fill_last = (fill_cnt == delay_cur - 1'b1);
  end

  assign wr_en   = ce & rst_n;
  assign rd_en   = ce & rst_n;
  assign regce   = ce & rst_n;
  assign wr_addr = ctr;
  // Only the low bits of delay_cur matter: the subtraction wraps modulo the depth.
  assign rd_addr = ctr - (delay_cur[ADDR_BITS-1:0] - LAT_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr        <= '0;
      fill_cnt   <= '0;
      delay_cur  <= DELAY_RST;
      state      <= FILL;
      dout_valid <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      err_range <= load_bad;
      if (ce) begin
        ctr <= ctr + 1'b1;
      end
      // A load overrides any fill completion on the same edge.
      if (load_ok) begin
        delay_cur  <= delay_in;
        fill_cnt   <= '0;
        state      <= FILL;
        dout_valid <= 1'b0;
      end else if (ce) begin
        if (state == FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_last) begin
            state      <= RUN;
            dout_valid <= 1'b1;
          end
        end else begin
          dout_valid <= 1'b1;
        end
      end
    end
  end

`ifdef BRAM_DELAY_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_cnt   <= '0;
      rejected_cnt <= '0;
    end else begin
      if (load_ok && (reload_cnt != '1)) begin
        reload_cnt <= reload_cnt + 1'b1;
      end
      if (load_bad && (rejected_cnt != '1)) begin
        rejected_cnt <= rejected_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Bench for bram_delay_ctrl: BRAM model, sample-history reference model, vectors and random run.
`timescale 1ns/1ps
module tb_bram_delay_ctrl;

  localparam int unsigned AB  = 10;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEF = 1024;
  localparam int unsigned N   = 1024;
  localparam int unsigned HN  = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ce = 1'b0;
  logic          delay_load = 1'b0;
  logic [AB:0]   delay_in = '0;
  logic [AB-1:0] wr_addr, rd_addr;
  logic          wr_en, rd_en, regce, dout_valid, err_range;
  logic [AB:0]   delay_cur;
  logic [15:0]   din = '0;
`ifdef BRAM_DELAY_CTRL_STATS_EN
  logic [15:0]   reload_cnt, rejected_cnt;
`endif

  int checks = 0;
  int failures = 0;

  bram_delay_ctrl #(
    .ADDR_BITS(AB),
    .LATENCY(LAT),
    .DEFAULT_DELAY(DEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .delay_in(delay_in),
    .delay_load(delay_load),
    .wr_addr(wr_addr),
    .wr_en(wr_en),
    .rd_addr(rd_addr),
    .rd_en(rd_en),
    .regce(regce),
    .delay_cur(delay_cur),
    .dout_valid(dout_valid),
    .err_range(err_range)
`ifdef BRAM_DELAY_CTRL_STATS_EN
    ,
    .reload_cnt(reload_cnt),
    .rejected_cnt(rejected_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Simple-dual-port BRAM, read-first, two read register stages (DO_REG used).
  logic [15:0] mem [N];
  logic [15:0] st1, st2;
  always @(posedge clk) begin
    if (rd_en) st1 <= mem[rd_addr];
    if (regce) st2 <= st1;
    if (wr_en) mem[wr_addr] <= din;
  end

  // Reference: count samples since reset and since the last accepted load.
  int unsigned m_samples = 0;
  int unsigned m_fill = 0;
  int unsigned m_delay = DEF;
  int unsigned m_reload = 0;
  int unsigned m_reject = 0;
  bit          m_err = 1'b0;
  logic [15:0] hist [HN];

  function automatic bit legal(input int unsigned d);
    return (d >= LAT + 1) && (d <= N);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_samples <= 0;
      m_fill    <= 0;
      m_delay   <= DEF;
      m_err     <= 1'b0;
      m_reload  <= 0;
      m_reject  <= 0;
    end else begin
      m_err <= delay_load && !legal(delay_in);
      if (ce) begin
        hist[m_samples % HN] <= din;
        m_samples <= m_samples + 1;
      end
      if (delay_load && legal(delay_in)) begin
        m_delay <= delay_in;
        m_fill  <= 0;
        if (m_reload < 65535) m_reload <= m_reload + 1;
      end else if (ce && m_fill < m_delay) begin
        m_fill <= m_fill + 1;
      end
      if (delay_load && !legal(delay_in) && m_reject < 65535) m_reject <= m_reject + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("wr_en", wr_en, ce & rst_n);
    chk("rd_en", rd_en, ce & rst_n);
    chk("regce", regce, ce & rst_n);
    chk("delay_cur", delay_cur, m_delay);
    chk("dout_valid", dout_valid, m_fill >= m_delay);
    chk("err_range", err_range, m_err);
    chk("wr_addr", wr_addr, m_samples % N);
    chk("rd_addr", rd_addr, (m_samples + N - (m_delay - LAT)) % N);
    if (rst_n && ce && m_fill >= m_delay)
      chk("dout", st2, hist[(m_samples - m_delay) % HN]);
`ifdef BRAM_DELAY_CTRL_STATS_EN
    chk("reload_cnt", reload_cnt, m_reload);
    chk("rejected_cnt", rejected_cnt, m_reject);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
    din = 16'($urandom);
  endtask

  task automatic do_load(input int unsigned d);
    delay_load = 1'b1;
    delay_in   = (AB+1)'(d);
    tick();
    delay_load = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int k);
    k = 0;
    while (dout_valid !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
  endtask

  typedef struct {
    int unsigned d;
    bit          err;
    int unsigned dcur;
    bit          valid;
  } vec_t;

  vec_t vec [9];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int unsigned d;

    vec[0] = '{2,    1'b1, 5,    1'b1};
    vec[1] = '{1025, 1'b1, 5,    1'b1};
    vec[2] = '{0,    1'b1, 5,    1'b1};
    vec[3] = '{2047, 1'b1, 5,    1'b1};
    vec[4] = '{5,    1'b0, 5,    1'b0};
    vec[5] = '{3,    1'b0, 3,    1'b0};
    vec[6] = '{1024, 1'b0, 1024, 1'b0};
    vec[7] = '{1,    1'b1, 1024, 1'b0};
    vec[8] = '{7,    1'b0, 7,    1'b0};

    #2 rst_n = 1'b0;
    ce = 1'b1;
    repeat (3) tick();
    chk("rst_delay_cur", delay_cur, DEF);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_en", wr_en, 0);
    rst_n = 1'b1;

    // Power-on fill with the default delay.
    wait_valid(2000, k);
    chk("t1_fill_clocks", k, 1024);
    repeat (1100) tick();

    // Shrink the delay while running.
    do_load(5);
    chk("t2_valid_drop", dout_valid, 0);
    chk("t2_delay_cur", delay_cur, 5);
    wait_valid(50, k);
    chk("t2_fill_clocks", k, 5);
    repeat (50) tick();

    for (int i = 0; i < 9; i++) begin
      do_load(vec[i].d);
      chk($sformatf("vec%0d_err", i), err_range, vec[i].err);
      chk($sformatf("vec%0d_delay_cur", i), delay_cur, vec[i].dcur);
      chk($sformatf("vec%0d_valid", i), dout_valid, vec[i].valid);
      tick();
      chk($sformatf("vec%0d_err_clear", i), err_range, 0);
    end
    wait_valid(50, k);
    chk("vec_refill_clocks", k, 6);
    repeat (20) tick();

    // Load landing on the fill-completion edge keeps the line in fill.
    do_load(4);
    repeat (3) tick();
    chk("lw_pre_valid", dout_valid, 0);
    do_load(4);
    chk("lw_valid_after", dout_valid, 0);
    wait_valid(50, k);
    chk("lw_fill_clocks", k, 4);
    repeat (10) tick();

    // Alternating ce: delay 8 needs 8 enabled cycles.
    ce = 1'b1;
    do_load(8);
    k = 0;
    while (dout_valid !== 1'b1 && k < 100) begin
      ce = ~ce;
      tick();
      k++;
    end
    chk("t4_fill_clocks", k, 16);
    repeat (40) begin
      ce = ~ce;
      tick();
    end
    ce = 1'b1;

    // Asynchronous reset in the middle of a fill.
    do_load(100);
    repeat (30) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t5_delay_cur", delay_cur, DEF);
    chk("t5_wr_addr", wr_addr, 0);
    chk("t5_dout_valid", dout_valid, 0);
    chk("t5_wr_en", wr_en, 0);
    tick();
    rst_n = 1'b1;
    wait_valid(2000, k);
    chk("t5_refill_clocks", k, 1024);
    repeat (20) tick();

    for (int i = 0; i < 4000; i++) begin
      ce = ($urandom_range(0, 9) < 7);
      delay_load = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: d = $urandom_range(3, 40);
        1: d = $urandom_range(0, 2);
        2: d = $urandom_range(1025, 2047);
        default: d = $urandom_range(3, 1024);
      endcase
      delay_in = (AB+1)'(d);
      if ($urandom_range(0, 1999) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    delay_load = 1'b0;
    ce = 1'b1;
    repeat (5) tick();

`ifdef BRAM_DELAY_CTRL_STATS_EN
    #3 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_load(10);
    do_load(2);
    do_load(20);
    do_load(1500);
    do_load(30);
    tick();
    chk("t6_reload_cnt", reload_cnt, 3);
    chk("t6_rejected_cnt", rejected_cnt, 2);
    delay_load = 1'b1;
    delay_in = (AB+1)'(10);
    repeat (70000) tick();
    delay_load = 1'b0;
    tick();
    chk("t6_reload_sat", reload_cnt, 16'hFFFF);
    chk("t6_rejected_hold", rejected_cnt, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
